matrix_vector_result_checker: RTL and testbench
===============================================

Name: matrix_vector_result_checker

Overview:
- Receiving-end checker for the pipelined matrix_mult_vector datapath.
- Captures each matrix/vector stimulus presented to the multiplier and delays it by the multiplier's pipeline latency.
- Computes the expected row dot products and compares them against the multiplier's output.
- Reports mismatches, pass/fail counts and the first failing result. It sits beside the stimulus counter and the multiplier in the test top level.

Parameters:
- M_ROWS, 3: number of matrix rows and result rows.
- N_COLUMNS, 3: matrix columns; also the vector length.
- DATA_WIDTH, 3: unsigned element width.
- OUT_WIDTH, 8: width of each result row; must be >= 1.
- LATENCY, 2: cycles from stimulus to valid multiplier output; must be >= 1.
- STOP_ON_ERROR, 0: when 1, checking halts after the first mismatch.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when high in IDLE, starts checking.
- clear  input  1  synchronous; clears counters, first-error capture and the halt condition.
- in_valid  input  1  stimulus on matrix_inp/vector_inp is valid this cycle.
- matrix_inp  input  M_ROWS*N_COLUMNS*DATA_WIDTH  element (r,c) at [(r*N_COLUMNS+c)*DATA_WIDTH +: DATA_WIDTH].
- vector_inp  input  N_COLUMNS*DATA_WIDTH  element c at [c*DATA_WIDTH +: DATA_WIDTH].
- dut_outp  input  M_ROWS*OUT_WIDTH  multiplier result; row r at [r*OUT_WIDTH +: OUT_WIDTH].
- mismatch  output  1  registered one-cycle pulse per failing compare.
- check_count  output  16  compares performed; saturates at 16'hFFFF.
- error_count  output  16  failing compares; saturates at 16'hFFFF.
- first_err_valid  output  1  sticky; a first error has been captured.
- first_err_exp  output  M_ROWS*OUT_WIDTH  expected value of the first failing compare.
- first_err_got  output  M_ROWS*OUT_WIDTH  dut_outp value of the first failing compare.
- halted  output  1  high in HALTED state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Delay line contents and valid bits clear to 0.
  - All outputs go to 0.
- Delay line:
  - LATENCY stages of {valid, matrix, vector}.
  - Stage 0 loads {in_valid & (state==RUN), matrix_inp, vector_inp}.
  - Every stage shifts every cycle; there is no stall.
  - A stimulus sampled at edge t is compared against dut_outp sampled at edge t+LATENCY.
- Expected value:
  - exp[r] = sum over c of matrix(r,c)*vector(c).
  - All operands are unsigned; products are 2*DATA_WIDTH bits.
  - Accumulation is performed at full width, then truncated to the low OUT_WIDTH bits (mod 2^OUT_WIDTH).
  - The expected value is computed from the delay-line tail, combinationally in the compare cycle.
- Compare, when the tail valid bit is 1 and state==RUN:
  - check_count increments (saturating).
  - On any row mismatch:
    - mismatch pulses on the next cycle.
    - error_count increments (saturating).
    - If first_err_valid==0: first_err_exp and first_err_got load, and first_err_valid sets.
- FSM states IDLE, RUN, HALTED:
  - IDLE -> RUN when enable=1.
  - RUN -> HALTED on a mismatch when STOP_ON_ERROR=1; otherwise RUN holds.
  - HALTED -> IDLE on clear.
  - In IDLE and HALTED, no new valid bits enter the delay line and no compares occur. In-flight entries drain without being counted.
- clear:
  - Zeroes check_count, error_count, first_err_* and the delay-line valid bits.
  - In HALTED, returns to IDLE.
  - If clear and a compare occur in the same cycle, clear wins.
- enable low while in RUN: remains in RUN. enable is only a start trigger.
- Reset mid-stream: all in-flight stimuli are discarded; the first compare occurs LATENCY cycles after the first valid input following re-enable.

Test Plan:
- Defaults, enable, in_valid=1; matrix all elements 1; vector elements {0,0,5} (vector_inp=9'd5); dut_outp=24'h050505 two cycles later -> exp 5 per row, mismatch=0, check_count=1, error_count=0.
- All elements 7, correct dut_outp={8'd147,8'd147,8'd147} -> no mismatch. Then drive row 1 as 8'd146 -> mismatch pulses one cycle after the compare; error_count=1; first_err_got=24'h939293, first_err_exp=24'h939393.
- OUT_WIDTH=7, all elements 7 -> exp 19 per row (147 mod 128); dut_outp of 19s passes.
- STOP_ON_ERROR=1, inject an error on the 3rd of 5 consecutive inputs -> halted=1; check_count=3, error_count=1, later stimuli not counted. Then clear -> IDLE, all counters 0.
- in_valid pattern 1,0,1 with LATENCY=2 -> compares occur only at edges t+2 and t+4; garbage dut_outp at t+3 is ignored; check_count=2.
- Pull rst_n low for 1 cycle with 2 stimuli in flight -> all outputs 0 immediately; no compares until re-enable plus LATENCY cycles.

Source files
------------

// File: rtl/matrix_vector_result_checker_if.sv
// matrix_vector_result_checker_if: stimulus, multiplier result and checker status bundle
interface matrix_vector_result_checker_if #(
  parameter int M_ROWS     = 3,
  parameter int N_COLUMNS  = 3,
  parameter int DATA_WIDTH = 3,
  parameter int OUT_WIDTH  = 8
);
  logic                                   enable;
  logic                                   clear;
  logic                                   in_valid;
  logic [M_ROWS*N_COLUMNS*DATA_WIDTH-1:0] matrix_inp;
  logic [N_COLUMNS*DATA_WIDTH-1:0]        vector_inp;
  logic [M_ROWS*OUT_WIDTH-1:0]            dut_outp;
  logic                                   mismatch;
  logic [15:0]                            check_count;
  logic [15:0]                            error_count;
  logic                                   first_err_valid;
  logic [M_ROWS*OUT_WIDTH-1:0]            first_err_exp;
  logic [M_ROWS*OUT_WIDTH-1:0]            first_err_got;
  logic                                   halted;
  modport master (
    output enable, clear, in_valid, matrix_inp, vector_inp, dut_outp,
    input  mismatch, check_count, error_count, first_err_valid, first_err_exp, first_err_got, halted
  );
  modport slave (
    input  enable, clear, in_valid, matrix_inp, vector_inp, dut_outp,
    output mismatch, check_count, error_count, first_err_valid, first_err_exp, first_err_got, halted
  );
endinterface

// File: rtl/matrix_vector_result_checker.sv
// matrix_vector_result_checker: delays each stimulus by the multiplier latency and checks its row dot products
module matrix_vector_result_checker #(
  parameter int M_ROWS        = 3,
  parameter int N_COLUMNS     = 3,
  parameter int DATA_WIDTH    = 3,
  parameter int OUT_WIDTH     = 8,
  parameter int LATENCY       = 2,
  parameter int STOP_ON_ERROR = 0
) (
  input logic                           clk,
  input logic                           rst_n,
  matrix_vector_result_checker_if.slave bus
);
  localparam int MW = M_ROWS*N_COLUMNS*DATA_WIDTH;
  localparam int VW = N_COLUMNS*DATA_WIDTH;
  localparam int RW = M_ROWS*OUT_WIDTH;
  localparam int AW = 2*DATA_WIDTH + $clog2(N_COLUMNS+1);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [MW-1:0] mat_q [LATENCY];
  logic [VW-1:0] vec_q [LATENCY];
  logic [RW-1:0] exp_w;
  logic [AW-1:0] acc;
  logic run, halted_w, cmp, err;
  logic [15:0] chk_q, chk_d, errc_q, errc_d;
  logic fev_q, fev_d, mm_q, mm_d;
  logic [RW-1:0] fexp_q, fexp_d, fgot_q, fgot_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.enable ? RUN : IDLE;
      RUN:     state_d = (STOP_ON_ERROR != 0 && cmp && err) ? HALTED : RUN;
      HALTED:  state_d = bus.clear ? IDLE : HALTED;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    run      = state_q == RUN;
    halted_w = state_q == HALTED;
  end
  always_comb begin
    vld_d[0] = bus.in_valid & run;
    for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
    if (bus.clear) vld_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        mat_q[i] <= '0;
        vec_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      mat_q[0] <= bus.matrix_inp;
      vec_q[0] <= bus.vector_inp;
      for (int i = 1; i < LATENCY; i++) begin
        mat_q[i] <= mat_q[i-1];
        vec_q[i] <= vec_q[i-1];
      end
    end
  // Accumulate at full width so truncation to OUT_WIDTH happens once, mod 2^OUT_WIDTH
  always_comb begin
    exp_w = '0;
    acc   = '0;
    for (int r = 0; r < M_ROWS; r++) begin
      acc = '0;
      for (int c = 0; c < N_COLUMNS; c++)
        acc = acc + AW'(mat_q[LATENCY-1][(r*N_COLUMNS+c)*DATA_WIDTH +: DATA_WIDTH])
                  * AW'(vec_q[LATENCY-1][c*DATA_WIDTH +: DATA_WIDTH]);
      exp_w[r*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(acc);
    end
  end
  assign err = exp_w != bus.dut_outp;
  assign cmp = vld_q[LATENCY-1] & run & ~bus.clear;
  always_comb begin
    chk_d  = bus.clear ? 16'd0 : chk_q + {15'd0, cmp && chk_q != 16'hFFFF};
    errc_d = bus.clear ? 16'd0 : errc_q + {15'd0, cmp && err && errc_q != 16'hFFFF};
    fev_d  = bus.clear ? 1'b0 : fev_q | (cmp & err);
    fexp_d = bus.clear ? '0 : (cmp && err && !fev_q) ? exp_w : fexp_q;
    fgot_d = bus.clear ? '0 : (cmp && err && !fev_q) ? bus.dut_outp : fgot_q;
    mm_d   = cmp & err;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chk_q  <= '0;
      errc_q <= '0;
      fev_q  <= 1'b0;
      fexp_q <= '0;
      fgot_q <= '0;
      mm_q   <= 1'b0;
    end else begin
      chk_q  <= chk_d;
      errc_q <= errc_d;
      fev_q  <= fev_d;
      fexp_q <= fexp_d;
      fgot_q <= fgot_d;
      mm_q   <= mm_d;
    end
  assign bus.mismatch        = mm_q;
  assign bus.check_count     = chk_q;
  assign bus.error_count     = errc_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_exp   = fexp_q;
  assign bus.first_err_got   = fgot_q;
  assign bus.halted          = halted_w;
endmodule

// File: tb/tb_matrix_vector_result_checker.sv
// tb_matrix_vector_result_checker: scenario tasks plus a randomized run against a dot-product model
module tb_matrix_vector_result_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  matrix_vector_result_checker_if if0 ();
  matrix_vector_result_checker_if #(.OUT_WIDTH(7)) if1 ();
  matrix_vector_result_checker_if if2 ();
  matrix_vector_result_checker u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  matrix_vector_result_checker #(.OUT_WIDTH(7)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  matrix_vector_result_checker #(.STOP_ON_ERROR(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  function automatic int row_sum(input logic [26:0] m, input logic [8:0] x, input int r);
    int s;
    s = 0;
    for (int c = 0; c < 3; c++) s += int'(m[(r*3+c)*3 +: 3]) * int'(x[c*3 +: 3]);
    return s;
  endfunction
  function automatic logic [23:0] exp8(input logic [26:0] m, input logic [8:0] x);
    logic [23:0] e;
    e = '0;
    for (int r = 0; r < 3; r++) e[r*8 +: 8] = 8'(row_sum(m, x, r) % 256);
    return e;
  endfunction
  function automatic logic [20:0] exp7(input logic [26:0] m, input logic [8:0] x);
    logic [20:0] e;
    e = '0;
    for (int r = 0; r < 3; r++) e[r*7 +: 7] = 7'(row_sum(m, x, r) % 128);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive0(input logic v, input logic [26:0] m, input logic [8:0] x, input logic [23:0] o);
    if0.in_valid = v; if0.matrix_inp = m; if0.vector_inp = x; if0.dut_outp = o;
  endtask
  task automatic drive2(input logic v, input logic [26:0] m, input logic [8:0] x, input logic [23:0] o);
    if2.in_valid = v; if2.matrix_inp = m; if2.vector_inp = x; if2.dut_outp = o;
  endtask
  task automatic clear0;
    if0.clear = 1'b1; tick; if0.clear = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if0.check_count !== 16'd0 || if0.error_count !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", if0.check_count, if0.error_count); end
    checks++; if (if0.mismatch !== 1'b0 || if0.first_err_valid !== 1'b0 || if0.halted !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b exp 000", if0.mismatch, if0.first_err_valid, if0.halted); end
    checks++; if (if0.first_err_exp !== 24'd0 || if0.first_err_got !== 24'd0) begin errors++; $display("FAIL reset_first got %h/%h exp 0/0", if0.first_err_exp, if0.first_err_got); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    if0.enable = 1'b1; tick; if0.enable = 1'b0;
    drive0(1'b1, 27'o111111111, 9'd5, 24'd0); tick;
    drive0(1'b0, 27'd0, 9'd0, 24'd0); tick;
    if0.dut_outp = 24'h050505; tick;
    checks++; if (if0.check_count !== 16'd1) begin errors++; $display("FAIL basic_check_count got %0d exp 1", if0.check_count); end
    checks++; if (if0.error_count !== 16'd0 || if0.mismatch !== 1'b0) begin errors++; $display("FAIL basic_no_error got err=%0d mm=%b exp 0/0", if0.error_count, if0.mismatch); end
  endtask

  task automatic test_error;
    clear0;
    checks++; if (if0.check_count !== 16'd0) begin errors++; $display("FAIL clear_check_count got %0d exp 0", if0.check_count); end
    drive0(1'b1, 27'o777777777, 9'o777, 24'd0); tick;
    drive0(1'b1, 27'o777777777, 9'o777, 24'd0); tick;
    drive0(1'b0, 27'd0, 9'd0, {8'd147, 8'd147, 8'd147}); tick;
    checks++; if (if0.mismatch !== 1'b0 || if0.check_count !== 16'd1) begin errors++; $display("FAIL err_good got mm=%b cnt=%0d exp 0/1", if0.mismatch, if0.check_count); end
    if0.dut_outp = {8'd147, 8'd146, 8'd147}; tick;
    checks++; if (if0.mismatch !== 1'b1 || if0.error_count !== 16'd1 || if0.check_count !== 16'd2) begin errors++; $display("FAIL err_bad got mm=%b err=%0d cnt=%0d exp 1/1/2", if0.mismatch, if0.error_count, if0.check_count); end
    checks++; if (if0.first_err_got !== 24'h939293 || if0.first_err_exp !== 24'h939393 || if0.first_err_valid !== 1'b1) begin errors++; $display("FAIL err_first got %h/%h v=%b exp 939293/939393/1", if0.first_err_got, if0.first_err_exp, if0.first_err_valid); end
    if0.dut_outp = 24'd0; tick;
    checks++; if (if0.mismatch !== 1'b0 || if0.error_count !== 16'd1) begin errors++; $display("FAIL err_pulse got mm=%b err=%0d exp 0/1", if0.mismatch, if0.error_count); end
  endtask

  task automatic test_out_width7;
    if1.clear = 1'b0; if1.enable = 1'b1; if1.dut_outp = '0; if1.in_valid = 1'b0; tick; if1.enable = 1'b0;
    if1.in_valid = 1'b1; if1.matrix_inp = 27'o777777777; if1.vector_inp = 9'o777; tick;
    if1.in_valid = 1'b0; tick;
    if1.dut_outp = exp7(27'o777777777, 9'o777); tick;
    checks++; if (exp7(27'o777777777, 9'o777) !== {7'd19, 7'd19, 7'd19}) begin errors++; $display("FAIL w7_model got %h exp %h", exp7(27'o777777777, 9'o777), {7'd19, 7'd19, 7'd19}); end
    checks++; if (if1.check_count !== 16'd1 || if1.error_count !== 16'd0 || if1.mismatch !== 1'b0) begin errors++; $display("FAIL w7_pass got cnt=%0d err=%0d mm=%b exp 1/0/0", if1.check_count, if1.error_count, if1.mismatch); end
  endtask

  task automatic test_stop_on_error;
    logic [26:0] m [5];
    logic [8:0] x [5];
    logic [23:0] o;
    if2.clear = 1'b0; if2.enable = 1'b1; drive2(1'b0, 27'd0, 9'd0, 24'd0); tick; if2.enable = 1'b0;
    for (int k = 0; k < 5; k++) begin m[k] = 27'($urandom); x[k] = 9'($urandom); end
    for (int k = 0; k < 9; k++) begin
      o = (k >= 2 && k < 7) ? exp8(m[k-2], x[k-2]) : 24'($urandom);
      if (k == 4) o = o ^ (24'd1 << $urandom_range(23, 0));
      if (k > 4) o = ~o;
      drive2(k < 5, k < 5 ? m[k] : 27'd0, k < 5 ? x[k] : 9'd0, o);
      tick;
    end
    checks++; if (if2.halted !== 1'b1) begin errors++; $display("FAIL stop_halted got %b exp 1", if2.halted); end
    checks++; if (if2.check_count !== 16'd3 || if2.error_count !== 16'd1) begin errors++; $display("FAIL stop_counts got %0d/%0d exp 3/1", if2.check_count, if2.error_count); end
    if2.clear = 1'b1; tick; if2.clear = 1'b0;
    checks++; if (if2.halted !== 1'b0 || if2.check_count !== 16'd0 || if2.error_count !== 16'd0 || if2.first_err_valid !== 1'b0) begin errors++; $display("FAIL stop_clear got h=%b cnt=%0d err=%0d fv=%b exp 0/0/0/0", if2.halted, if2.check_count, if2.error_count, if2.first_err_valid); end
    for (int k = 0; k < 4; k++) begin drive2(1'b1, 27'($urandom), 9'($urandom), 24'($urandom)); tick; end
    checks++; if (if2.check_count !== 16'd0 || if2.error_count !== 16'd0) begin errors++; $display("FAIL stop_idle got %0d/%0d exp 0/0", if2.check_count, if2.error_count); end
  endtask

  task automatic test_gap;
    logic [26:0] ma, mb;
    logic [8:0] xa, xb;
    clear0;
    ma = 27'($urandom); mb = 27'($urandom); xa = 9'($urandom); xb = 9'($urandom);
    drive0(1'b1, ma, xa, 24'd0); tick;
    drive0(1'b0, 27'($urandom), 9'($urandom), 24'd0); tick;
    drive0(1'b1, mb, xb, exp8(ma, xa)); tick;
    checks++; if (if0.check_count !== 16'd1) begin errors++; $display("FAIL gap_first got %0d exp 1", if0.check_count); end
    drive0(1'b0, 27'd0, 9'd0, ~exp8(ma, xa)); tick;
    checks++; if (if0.check_count !== 16'd1 || if0.mismatch !== 1'b0) begin errors++; $display("FAIL gap_garbage got cnt=%0d mm=%b exp 1/0", if0.check_count, if0.mismatch); end
    drive0(1'b0, 27'd0, 9'd0, exp8(mb, xb)); tick;
    checks++; if (if0.check_count !== 16'd2 || if0.error_count !== 16'd0) begin errors++; $display("FAIL gap_second got %0d/%0d exp 2/0", if0.check_count, if0.error_count); end
  endtask

  task automatic test_random;
    localparam int N = 200;
    logic v [N];
    logic bad [N];
    logic [26:0] m [N];
    logic [8:0] x [N];
    logic [23:0] o, fexp, fgot;
    int cnt, err;
    logic fv, mm;
    clear0;
    cnt = 0; err = 0; fv = 1'b0; fexp = '0; fgot = '0;
    for (int k = 0; k < N; k++) begin
      v[k] = ($urandom_range(3, 0) != 0); bad[k] = ($urandom_range(4, 0) == 0);
      m[k] = 27'($urandom); x[k] = 9'($urandom);
    end
    for (int k = 0; k < N + 2; k++) begin
      mm = 1'b0;
      o = 24'($urandom);
      if (k >= 2 && v[k-2]) begin
        o = exp8(m[k-2], x[k-2]);
        if (bad[k-2]) o = o ^ (24'd1 << $urandom_range(23, 0));
      end
      drive0(k < N ? v[k] : 1'b0, k < N ? m[k] : 27'd0, k < N ? x[k] : 9'd0, o);
      tick;
      if (k >= 2 && v[k-2]) begin
        cnt++;
        if (bad[k-2]) begin
          err++; mm = 1'b1;
          if (!fv) begin fv = 1'b1; fexp = exp8(m[k-2], x[k-2]); fgot = o; end
        end
      end
      checks++; if (if0.check_count !== 16'(cnt) || if0.error_count !== 16'(err) || if0.mismatch !== mm) begin errors++; $display("FAIL rand_cycle%0d got cnt=%0d err=%0d mm=%b exp %0d/%0d/%b", k, if0.check_count, if0.error_count, if0.mismatch, cnt, err, mm); end
    end
    checks++; if (if0.first_err_valid !== fv || if0.first_err_exp !== fexp || if0.first_err_got !== fgot) begin errors++; $display("FAIL rand_first got %b/%h/%h exp %b/%h/%h", if0.first_err_valid, if0.first_err_exp, if0.first_err_got, fv, fexp, fgot); end
  endtask

  task automatic test_reset_midstream;
    logic [26:0] m;
    logic [8:0] x;
    drive0(1'b1, 27'($urandom), 9'($urandom), 24'd0); tick;
    drive0(1'b1, 27'($urandom), 9'($urandom), 24'd0); tick;
    rst_n = 1'b0;
    #1;
    checks++; if (if0.check_count !== 16'd0 || if0.error_count !== 16'd0 || if0.first_err_valid !== 1'b0 || if0.mismatch !== 1'b0) begin errors++; $display("FAIL rst_mid_async got %0d/%0d/%b/%b exp 0/0/0/0", if0.check_count, if0.error_count, if0.first_err_valid, if0.mismatch); end
    checks++; if (if0.first_err_exp !== 24'd0 || if0.first_err_got !== 24'd0) begin errors++; $display("FAIL rst_mid_first got %h/%h exp 0/0", if0.first_err_exp, if0.first_err_got); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin drive0(1'b1, 27'($urandom), 9'($urandom), 24'($urandom)); tick; end
    checks++; if (if0.check_count !== 16'd0 || if0.error_count !== 16'd0) begin errors++; $display("FAIL rst_mid_idle got %0d/%0d exp 0/0", if0.check_count, if0.error_count); end
    drive0(1'b0, 27'd0, 9'd0, 24'd0);
    if0.enable = 1'b1; tick; if0.enable = 1'b0;
    m = 27'($urandom); x = 9'($urandom);
    drive0(1'b1, m, x, 24'd0); tick;
    drive0(1'b0, 27'd0, 9'd0, 24'd0); tick;
    checks++; if (if0.check_count !== 16'd0) begin errors++; $display("FAIL rst_mid_early got %0d exp 0", if0.check_count); end
    if0.dut_outp = exp8(m, x); tick;
    checks++; if (if0.check_count !== 16'd1 || if0.error_count !== 16'd0) begin errors++; $display("FAIL rst_mid_first_cmp got %0d/%0d exp 1/0", if0.check_count, if0.error_count); end
  endtask

  initial begin
    if0.enable = 1'b0; if0.clear = 1'b0; drive0(1'b0, 27'd0, 9'd0, 24'd0);
    if1.enable = 1'b0; if1.clear = 1'b0; if1.in_valid = 1'b0; if1.matrix_inp = '0; if1.vector_inp = '0; if1.dut_outp = '0;
    if2.enable = 1'b0; if2.clear = 1'b0; drive2(1'b0, 27'd0, 9'd0, 24'd0);
    test_reset;
    test_basic;
    test_error;
    test_out_width7;
    test_stop_on_error;
    test_gap;
    test_random;
    test_reset_midstream;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
